// File: rtl/axis_pkt_rr_arbiter.sv
// ---------------------------------------------------------------------------
// axis_pkt_rr_arbiter
//
// Round-robin, packet-locked arbiter that shares one AXI-stream style channel
// (data/valid/ready/last) between NUM_SRC requesters. Once a source is
// granted it keeps the channel until the handshake of its last beat, so
// packets never interleave. A beat watchdog forces s_last after MAX_BEATS
// beats and flags the truncation with a one-cycle trunc_err pulse.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   m_data_in  requester data, source i at [i*DATA_W +: DATA_W]
//   m_valid    per-requester valid
//   m_last     per-requester last-beat flag
//   m_ready    per-requester ready (only the granted source can see ready)
//   s_data_out shared-channel data
//   s_valid    shared-channel valid
//   s_last     shared-channel last (source last OR watchdog force)
//   s_ready    shared-channel ready
//   grant_id   index of the currently / most recently granted source
//   busy       high while a packet holds the channel
//   trunc_err  one-cycle pulse after a watchdog-truncated packet ends
//
// GID_W must equal $clog2(NUM_SRC).
// ---------------------------------------------------------------------------
module axis_pkt_rr_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = 64,
  parameter int GID_W     = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_SRC*DATA_W-1:0]   m_data_in,
  input  logic [NUM_SRC-1:0]          m_valid,
  input  logic [NUM_SRC-1:0]          m_last,
  output logic [NUM_SRC-1:0]          m_ready,
  output logic [DATA_W-1:0]           s_data_out,
  output logic                        s_valid,
  output logic                        s_last,
  input  logic                        s_ready,
  output logic [GID_W-1:0]            grant_id,
  output logic                        busy,
  output logic                        trunc_err
);

  // Beat counter only needs to reach MAX_BEATS-1; the packet is forced to
  // end there and the counter returns to zero.
  localparam int CNT_W = $clog2(MAX_BEATS);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [GID_W-1:0]   grant_q, grant_d;
  logic [GID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               trunc_err_q, trunc_err_d;

  logic [GID_W-1:0]   cand_s;
  logic               found_s;
  logic               force_last_s;
  logic               xfer_s;

  // Next-state, arbitration and combinational channel pass-through.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    beat_cnt_d   = beat_cnt_q;
    trunc_err_d  = 1'b0;
    cand_s       = rr_ptr_q;
    found_s      = 1'b0;
    force_last_s = 1'b0;
    xfer_s       = 1'b0;
    m_ready      = '0;
    s_data_out   = '0;
    s_valid      = 1'b0;
    s_last       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Search rr_ptr+1, rr_ptr+2, ... with wrap; the first valid wins.
        // The pointer itself is the last candidate so a lone requester that
        // just finished can still be served again.
        for (int i = 1; i <= NUM_SRC; i++) begin
          cand_s = GID_W'((int'(rr_ptr_q) + i) % NUM_SRC);
          if (!found_s && m_valid[cand_s]) begin
            found_s = 1'b1;
            grant_d = cand_s;
          end else begin
            found_s = found_s;
          end
        end
        if (found_s) begin
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_BUSY: begin
        force_last_s     = (beat_cnt_q == CNT_W'(MAX_BEATS - 1));
        s_data_out       = m_data_in[grant_q*DATA_W +: DATA_W];
        s_valid          = m_valid[grant_q];
        s_last           = m_last[grant_q] | force_last_s;
        m_ready[grant_q] = s_ready;
        xfer_s           = s_valid & s_ready;
        if (xfer_s) begin
          if (s_last) begin
            // Packet done: release, and the finished source becomes lowest
            // priority for the next arbitration.
            state_d     = ST_IDLE;
            rr_ptr_d    = grant_q;
            beat_cnt_d  = '0;
            trunc_err_d = force_last_s & ~m_last[grant_q];
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end else begin
          // Stall or bubble: hold everything, keep the grant.
          beat_cnt_d = beat_cnt_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, grant, pointer, beat counter and error pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= GID_W'(NUM_SRC - 1);
      beat_cnt_q  <= '0;
      trunc_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      trunc_err_q <= trunc_err_d;
    end
  end

  assign grant_id  = grant_q;
  assign busy      = (state_q == ST_BUSY);
  assign trunc_err = trunc_err_q;

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for axis_pkt_rr_arbiter (MAX_BEATS = 4 so the
// watchdog is reachable). Inputs change 1 ns after a rising edge; outputs
// are checked 1 ns after that, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_axis_pkt_rr_arbiter;

  localparam int NUM_SRC   = 4;
  localparam int DATA_W    = 8;
  localparam int MAX_BEATS = 4;
  localparam int GID_W     = 2;

  logic                      clk;
  logic                      reset;
  logic [NUM_SRC*DATA_W-1:0] m_data_in;
  logic [NUM_SRC-1:0]        m_valid;
  logic [NUM_SRC-1:0]        m_last;
  logic [NUM_SRC-1:0]        m_ready;
  logic [DATA_W-1:0]         s_data_out;
  logic                      s_valid;
  logic                      s_last;
  logic                      s_ready;
  logic [GID_W-1:0]          grant_id;
  logic                      busy;
  logic                      trunc_err;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  axis_pkt_rr_arbiter #(
    .NUM_SRC  (NUM_SRC),
    .DATA_W   (DATA_W),
    .MAX_BEATS(MAX_BEATS),
    .GID_W    (GID_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .m_data_in (m_data_in),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .s_data_out(s_data_out),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .grant_id  (grant_id),
    .busy      (busy),
    .trunc_err (trunc_err)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic [7:0] d, input logic v, input logic l);
    m_data_in[i*DATA_W +: DATA_W] = d;
    m_valid[i] = v;
    m_last[i]  = l;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},    32'(busy),    32'd0);
    check({tag, "_svalid"},  32'(s_valid), 32'd0);
    check({tag, "_mready"},  32'(m_ready), 32'd0);
  endtask

  initial begin
    int e;
    reset     = 1'b0;
    m_data_in = '0;
    m_valid   = '0;
    m_last    = '0;
    s_ready   = 1'b1;

    // ---------------- reset then idle ----------------
    #1;
    check_idle("rst");
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_data",  32'(s_data_out), 32'd0);
    check("rst_trunc", 32'(trunc_err), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    check_idle("idle0");
    tick();
    check_idle("idle1");
    check("idle1_grant", 32'(grant_id), 32'd0);

    // ---------------- single requester src2 ----------------
    drive(2, 8'h11, 1'b1, 1'b0);
    #1;
    check_idle("s2_arb");
    tick();
    check("s2_grant",  32'(grant_id),   32'd2);
    check("s2_busy",   32'(busy),       32'd1);
    check("s2_d0",     32'(s_data_out), 32'h11);
    check("s2_l0",     32'(s_last),     32'd0);
    check("s2_mready", 32'(m_ready),    32'b0100);
    tick();
    drive(2, 8'h22, 1'b1, 1'b0);
    #1;
    check("s2_d1", 32'(s_data_out), 32'h22);
    check("s2_l1", 32'(s_last),     32'd0);
    tick();
    drive(2, 8'h33, 1'b1, 1'b1);
    #1;
    check("s2_d2", 32'(s_data_out), 32'h33);
    check("s2_l2", 32'(s_last),     32'd1);
    tick();
    drive(2, 8'h00, 1'b0, 1'b0);
    #1;
    check_idle("s2_done");

    // ---------------- round-robin fairness (fresh pointer) ----------------
    reset = 1'b0;
    #1;
    tick();
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      e = k % NUM_SRC;
      for (int i = 0; i < NUM_SRC; i++) drive(i, 8'((i << 4) | 0), 1'b1, 1'b0);
      #1;
      check("rr_idle_busy", 32'(busy), 32'd0);
      tick();
      check("rr_grant",  32'(grant_id),   32'(e));
      check("rr_mready", 32'(m_ready),    32'(1 << e));
      check("rr_d0",     32'(s_data_out), 32'((e << 4) | 0));
      check("rr_l0",     32'(s_last),     32'd0);
      tick();
      drive(e, 8'((e << 4) | 1), 1'b1, 1'b1);
      #1;
      check("rr_grant1", 32'(grant_id),   32'(e));
      check("rr_d1",     32'(s_data_out), 32'((e << 4) | 1));
      check("rr_l1",     32'(s_last),     32'd1);
      tick();
    end
    m_valid = '0;
    m_last  = '0;
    #1;
    check_idle("rr_end");

    // ---------------- backpressure and bubble on src1 ----------------
    drive(1, 8'hA1, 1'b1, 1'b0);
    tick();
    #1;
    check("bp_grant", 32'(grant_id),   32'd1);
    check("bp_d1",    32'(s_data_out), 32'hA1);
    check("bp_mr1",   32'(m_ready),    32'b0010);
    tick();                                   // A1 accepted
    drive(1, 8'hA2, 1'b1, 1'b0);
    drive(0, 8'h0F, 1'b1, 1'b0);              // competing request, ignored
    s_ready = 1'b0;
    #1;
    check("bp_stall_v",  32'(s_valid),    32'd1);
    check("bp_stall_d",  32'(s_data_out), 32'hA2);
    check("bp_stall_mr", 32'(m_ready),    32'b0000);
    tick();                                   // stalled
    s_ready = 1'b1;
    m_valid[1] = 1'b0;                        // bubble
    #1;
    check("bp_bub_v",     32'(s_valid),  32'd0);
    check("bp_bub_busy",  32'(busy),     32'd1);
    check("bp_bub_grant", 32'(grant_id), 32'd1);
    check("bp_bub_mr",    32'(m_ready),  32'b0010);
    tick();                                   // no transfer
    m_valid[1] = 1'b1;
    #1;
    check("bp_d2",  32'(s_data_out), 32'hA2);
    check("bp_l2",  32'(s_last),     32'd0);
    tick();                                   // A2 accepted (count 2)
    drive(1, 8'hA3, 1'b1, 1'b1);
    s_ready = 1'b0;
    #1;
    check("bp_d3",    32'(s_data_out), 32'hA3);
    check("bp_l3",    32'(s_last),     32'd1);
    check("bp_mr3",   32'(m_ready),    32'b0000);
    tick();                                   // stalled on last
    s_ready = 1'b1;
    drive(0, 8'h00, 1'b0, 1'b0);
    #1;
    check("bp_grant3", 32'(grant_id), 32'd1);
    check("bp_mr3b",   32'(m_ready),  32'b0010);
    tick();                                   // A3 accepted
    drive(1, 8'h00, 1'b0, 1'b0);
    #1;
    check_idle("bp_done");
    check("bp_trunc", 32'(trunc_err), 32'd0);

    // ---------------- watchdog on src0 (MAX_BEATS = 4) ----------------
    drive(0, 8'hD1, 1'b1, 1'b0);
    tick();
    check("wd_grant", 32'(grant_id),   32'd0);
    check("wd_d1",    32'(s_data_out), 32'hD1);
    check("wd_l1",    32'(s_last),     32'd0);
    tick();
    drive(0, 8'hD2, 1'b1, 1'b0);
    #1;
    check("wd_l2", 32'(s_last), 32'd0);
    tick();
    drive(0, 8'hD3, 1'b1, 1'b0);
    #1;
    check("wd_l3", 32'(s_last), 32'd0);
    tick();
    drive(0, 8'hD4, 1'b1, 1'b0);
    #1;
    check("wd_d4",     32'(s_data_out), 32'hD4);
    check("wd_l4",     32'(s_last),     32'd1);
    check("wd_trunc4", 32'(trunc_err),  32'd0);
    tick();
    drive(0, 8'hD5, 1'b1, 1'b0);
    #1;
    check("wd_idle_busy", 32'(busy),      32'd0);
    check("wd_pulse",     32'(trunc_err), 32'd1);
    check("wd_idle_v",    32'(s_valid),   32'd0);
    tick();
    check("wd_pulse_end", 32'(trunc_err),  32'd0);
    check("wd_regrant",   32'(grant_id),   32'd0);
    check("wd_d5",        32'(s_data_out), 32'hD5);
    check("wd_l5",        32'(s_last),     32'd0);
    tick();
    drive(0, 8'hD6, 1'b1, 1'b1);
    #1;
    check("wd_d6", 32'(s_data_out), 32'hD6);
    check("wd_l6", 32'(s_last),     32'd1);
    tick();
    drive(0, 8'h00, 1'b0, 1'b0);
    #1;
    check_idle("wd_done");
    check("wd_no_pulse", 32'(trunc_err), 32'd0);

    // ---------------- mid-packet reset on src3 ----------------
    drive(3, 8'hC1, 1'b1, 1'b0);
    tick();
    check("mr_grant", 32'(grant_id), 32'd3);
    tick();                                   // C1 accepted
    drive(3, 8'hC2, 1'b1, 1'b0);
    #1;
    check("mr_d2", 32'(s_data_out), 32'hC2);
    drive(0, 8'h5A, 1'b1, 1'b0);
    reset = 1'b0;
    #1;
    check_idle("mr_rst");
    check("mr_rst_grant", 32'(grant_id),   32'd0);
    check("mr_rst_data",  32'(s_data_out), 32'd0);
    check("mr_rst_last",  32'(s_last),     32'd0);
    check("mr_rst_trunc", 32'(trunc_err),  32'd0);
    tick();
    reset = 1'b1;
    #1;
    check_idle("mr_rel");
    tick();
    check("mr_src0_first", 32'(grant_id),   32'd0);
    check("mr_src0_data",  32'(s_data_out), 32'h5A);
    check("mr_src0_trunc", 32'(trunc_err),  32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/axis_pkt_rr_arbiter.md
Name: axis_pkt_rr_arbiter

Overview:
Round-robin, packet-locked arbiter. It shares one 8-bit AXI-stream style channel (data/valid/ready/last) between NUM_SRC upstream requesters. A grant is held from the first beat of a packet until its last-beat handshake, so packets never interleave. The block sits directly in front of axi_8bit_reg and drives that register's m_* input side.

Parameters:
- NUM_SRC, 4, number of requesters (2..8)
- DATA_W, 8, beat width in bits
- MAX_BEATS, 64, watchdog limit on beats per packet (>=2)
- GID_W, 2, grant-index width; must equal clog2(NUM_SRC)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- m_data_in  in  NUM_SRC*DATA_W  requester data; src i occupies bits [i*DATA_W +: DATA_W]
- m_valid  in  NUM_SRC  per-requester valid
- m_last  in  NUM_SRC  per-requester last-beat flag
- m_ready  out  NUM_SRC  per-requester ready
- s_data_out  out  DATA_W  shared-channel data
- s_valid  out  1  shared-channel valid
- s_last  out  1  shared-channel last
- s_ready  in  1  shared-channel ready
- grant_id  out  GID_W  index of the currently granted source
- busy  out  1  high while a packet is locked
- trunc_err  out  1  one-cycle pulse when the watchdog truncates a packet

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, grant_id=0, rr_ptr=NUM_SRC-1 (so src0 has top priority first), beat_cnt=0.
  - busy=0, trunc_err=0, s_valid=0, s_last=0, s_data_out=0, m_ready=0.
- State IDLE:
  - All m_ready=0, s_valid=0, s_data_out=0.
  - If any m_valid is high, grant goes to the first requester with m_valid=1, searching rr_ptr+1, rr_ptr+2, … with wrap modulo NUM_SRC.
  - On the next edge: grant_id is registered, state moves to BUSY, busy=1.
  - This gives 1 cycle of arbitration latency; the first beat can transfer in the first BUSY cycle.
- State BUSY (g=grant_id):
  - Combinational pass-through: s_data_out=m_data_in[g], s_valid=m_valid[g], s_last=m_last[g] OR force_last.
  - m_ready[g]=s_ready; every other m_ready=0.
  - A beat transfers when s_valid&s_ready. Each transfer increments beat_cnt.
  - force_last is high when beat_cnt==MAX_BEATS-1.
  - On a transfer with s_last=1:
    - next state is IDLE, rr_ptr<=g, beat_cnt<=0, busy<=0;
    - if force_last=1 and m_last[g]=0, trunc_err pulses for exactly 1 cycle; the remainder of that packet is arbitrated later as a new packet.
  - Valid deasserting mid-packet (a bubble) does not release the grant.
  - s_ready=0 stalls everything: no counter change, and the outputs follow the source.
- Back-to-back: there is always exactly one IDLE cycle between packets. Maximum throughput is 1 packet per (beats+1) cycles.
- Requests that arrive while BUSY are ignored until IDLE. A requester whose valid drops while IDLE simply loses eligibility; no request is latched.
- rr_ptr only advances on packet completion, so every continuously requesting source is served within NUM_SRC packets.
- Reset asserted mid-packet: immediate return to IDLE values; the partial packet is dropped with no error pulse.
- Single-beat packet (m_last=1 on the first beat): BUSY lasts 1 cycle when s_ready=1.

Test Plan:
- Reset then idle: reset low 2 cycles, no valid → busy=0, s_valid=0, m_ready=4'b0000, grant_id=0 throughout.
- Single requester: src2 sends 3 beats 0x11,0x22,0x33, last on 0x33, s_ready=1 → 1 cycle after valid, grant_id=2; s_data_out shows 0x11,0x22,0x33 on consecutive cycles; s_last only on 0x33; IDLE the next cycle.
- Round-robin fairness: all 4 sources valid continuously with 2-beat packets → grant order 0,1,2,3,0,1; no two packets ever interleave.
- Backpressure and bubble: src1 packet with s_ready toggling 1,0,1 and a one-cycle m_valid[1] drop → each beat is transferred exactly once; grant stays on src1 until the last handshake; m_ready[0,2,3]=0 throughout.
- Watchdog: MAX_BEATS=4, src0 streams 6 beats with no last → s_last forced on beat 4; trunc_err pulses 1 cycle; beats 5-6 are delivered as a new packet after re-arbitration.
- Mid-packet reset: reset low during beat 2 of a src3 packet → all outputs go to reset values immediately; after release, src0 wins first if it is requesting.
